pe_result_serializer: RTL and testbench

Output-side counterpart of the padded-row input path: accepts one parallel result row per handshake from the PE array and serializes it MSB-byte-first into an 8-bit stream for the output buffer. It tracks row and column position within a frame, flags the last byte of the frame, and double-buffers rows so the PE array can deliver the next row while the current one drains.

---
 rtl/pe_result_serializer_if.sv | 36 +++
 rtl/pe_result_serializer.sv | 128 ++++++++++++
 tb/tb_pe_result_serializer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_result_serializer_if.sv
// Row-in / byte-out handshake bundle for pe_result_serializer.
// slave = serializer side, master = PE array / output buffer side.
interface pe_result_serializer_if #(
    parameter int ROW_BYTES = 32
);
    logic [ROW_BYTES*8-1:0] i_row_data;
    logic                   i_row_vld;
    logic                   o_row_rdy;
    logic [7:0]             o_data;
    logic                   o_data_vld;
    logic                   i_data_rdy;
    logic                   o_frame_last;
    logic                   o_busy;

    modport slave (
        input  i_row_data,
        input  i_row_vld,
        input  i_data_rdy,
        output o_row_rdy,
        output o_data,
        output o_data_vld,
        output o_frame_last,
        output o_busy
    );

    modport master (
        output i_row_data,
        output i_row_vld,
        output i_data_rdy,
        input  o_row_rdy,
        input  o_data,
        input  o_data_vld,
        input  o_frame_last,
        input  o_busy
    );
endinterface

// File: rtl/pe_result_serializer.sv
// Serializes PE result rows MSB-byte-first onto an 8-bit stream through a shift + pending
// double buffer, tracking row/column within a frame. Optional macro: PE_OUT_RELU_EN.
module pe_result_serializer #(
    parameter int ROW_BYTES = 32,
    parameter int ROWS      = 32
) (
    input  logic                 dout_clk,
    input  logic                 rst_n,
    input  logic                 en,
    pe_result_serializer_if.slave bus
);
    localparam int ROW_W     = ROW_BYTES * 8;
    localparam int COL_W     = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
    localparam int ROW_CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0]     LAST_COL = COL_W'(ROW_BYTES - 1);
    localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(ROWS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       srData_q, srData_d;
    logic [ROW_W-1:0]       prData_q, prData_d;
    logic                   prVld_q, prVld_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_CNT_W-1:0]   row_q, row_d;
    logic [7:0]             data_q, data_d;
    logic                   dataVld_q, dataVld_d;
    logic                   frameLast_q, frameLast_d;
    logic                   busy_q, busy_d;
    logic                   rdyArm_q;
    logic                   rowAcc, byteXfer, lastXfer;

    function automatic logic [ROW_W-1:0] loadFilter(input logic [ROW_W-1:0] rowIn);
        logic [ROW_W-1:0] res;
        res = rowIn;
`ifdef PE_OUT_RELU_EN
        for (int k = 0; k < ROW_BYTES; k++) begin
            if (rowIn[8*k+7]) begin
                res[8*k +: 8] = 8'h00;
            end
        end
`endif
        return res;
    endfunction

    // rdyArm_q keeps the row port closed until the first edge after reset release.
    assign bus.o_row_rdy = en && rdyArm_q && !prVld_q;
    assign rowAcc        = bus.i_row_vld && bus.o_row_rdy;
    assign byteXfer      = en && (state_q == SEND) && bus.i_data_rdy;
    assign lastXfer      = byteXfer && (col_q == LAST_COL);

    always_comb begin
        state_d  = state_q;
        srData_d = srData_q;
        prData_d = prData_q;
        prVld_d  = prVld_q;
        col_d    = col_q;
        row_d    = row_q;

        if (en) begin
            if (byteXfer) begin
                srData_d = srData_q << 8;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_CNT_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end

            // SR is free this cycle: refill from PR first, else take the incoming row directly.
            if ((state_q == IDLE) || lastXfer) begin
                if (prVld_q) begin
                    srData_d = loadFilter(prData_q);
                    prVld_d  = 1'b0;
                    state_d  = SEND;
                end else if (rowAcc) begin
                    srData_d = loadFilter(bus.i_row_data);
                    state_d  = SEND;
                end else begin
                    state_d  = IDLE;
                end
            end else if (rowAcc) begin
                prData_d = bus.i_row_data;
                prVld_d  = 1'b1;
            end
        end

        data_d      = (state_d == SEND) ? srData_d[ROW_W-1 -: 8] : 8'h00;
        dataVld_d   = (state_d == SEND);
        frameLast_d = (state_d == SEND) && (row_d == LAST_ROW) && (col_d == LAST_COL);
        busy_d      = (state_d == SEND) || prVld_d;
    end

    always_ff @(posedge dout_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            srData_q    <= '0;
            prData_q    <= '0;
            prVld_q     <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            data_q      <= 8'h00;
            dataVld_q   <= 1'b0;
            frameLast_q <= 1'b0;
            busy_q      <= 1'b0;
            rdyArm_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            srData_q    <= srData_d;
            prData_q    <= prData_d;
            prVld_q     <= prVld_d;
            col_q       <= col_d;
            row_q       <= row_d;
            data_q      <= data_d;
            dataVld_q   <= dataVld_d;
            frameLast_q <= frameLast_d;
            busy_q      <= busy_d;
            rdyArm_q    <= 1'b1;
        end
    end

    // Valid flags are masked by en so a disabled block never advertises a byte.
    assign bus.o_data       = data_q;
    assign bus.o_data_vld   = dataVld_q && en;
    assign bus.o_frame_last = frameLast_q && en;
    assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_pe_result_serializer.sv
// Bench for pe_result_serializer: byte-queue reference model checked every cycle,
// a vector table for byte pass-through/ReLU, and hand-written multi-cycle sequences.
module tb_pe_result_serializer;
    localparam int ROW_BYTES = 32;
    localparam int ROWS      = 32;
    localparam int ROW_W     = ROW_BYTES * 8;
    localparam int FRAME     = ROW_BYTES * ROWS;
`ifdef PE_OUT_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] inByte;
        logic [7:0] outByte;
    } vec_t;

    logic dout_clk;
    logic rst_n;
    logic en;

    pe_result_serializer_if #(.ROW_BYTES(ROW_BYTES)) bus ();

    pe_result_serializer #(
        .ROW_BYTES(ROW_BYTES),
        .ROWS     (ROWS)
    ) dut (
        .dout_clk(dout_clk),
        .rst_n   (rst_n),
        .en      (en),
        .bus     (bus)
    );

    initial dout_clk = 1'b0;
    always #5 dout_clk = ~dout_clk;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] expQ[$];
    int         bytesSent;
    int         rowsAccepted;
    bit         armed;
    bit         expRdy;
    bit         expVld;
    vec_t       vecs[8];

    function automatic logic [7:0] reluRef(input logic [7:0] b);
        if (RELU_ON && b[7]) return 8'h00;
        return b;
    endfunction

    function automatic logic [ROW_W-1:0] randomRow();
        logic [ROW_W-1:0] r;
        for (int w = 0; w < ROW_W / 32; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model view: the queue holds every accepted byte not yet handed downstream.
    // More than one row's worth queued means the pending register is occupied.
    task automatic checkOutput();
        expRdy = rst_n && armed && en && (expQ.size() <= ROW_BYTES);
        expVld = rst_n && en && (expQ.size() > 0);
        compare("row_rdy", 32'(bus.o_row_rdy), 32'(expRdy));
        compare("data_vld", 32'(bus.o_data_vld), 32'(expVld));
        if (expVld) compare("data", 32'(bus.o_data), 32'(expQ[0]));
        compare("frame_last", 32'(bus.o_frame_last),
                32'(expVld && ((bytesSent % FRAME) == FRAME - 1)));
        compare("busy", 32'(bus.o_busy), 32'(expQ.size() > 0));
    endtask

    task automatic applyStimulus(input logic rowVld, input logic [ROW_W-1:0] rowData,
                                 input logic dataRdy, input logic enV);
        @(posedge dout_clk);
        #1;
        bus.i_row_vld  = rowVld;
        bus.i_row_data = rowData;
        bus.i_data_rdy = dataRdy;
        en             = enV;
        #1;
        checkOutput();
        if (rst_n) begin
            if (expVld && dataRdy) begin
                void'(expQ.pop_front());
                bytesSent++;
            end
            if (expRdy && rowVld) begin
                for (int k = 0; k < ROW_BYTES; k++) expQ.push_back(reluRef(rowData[ROW_W-1-8*k -: 8]));
                rowsAccepted++;
            end
            armed = 1'b1;
        end
    endtask

    task automatic resetDut();
        @(posedge dout_clk);
        #1;
        rst_n          = 1'b0;
        bus.i_row_vld  = 1'b0;
        bus.i_data_rdy = 1'b1;
        en             = 1'b1;
        #1;
        expQ.delete();
        bytesSent    = 0;
        rowsAccepted = 0;
        armed        = 1'b0;
        compare("rst_row_rdy", 32'(bus.o_row_rdy), 32'd0);
        compare("rst_data_vld", 32'(bus.o_data_vld), 32'd0);
        compare("rst_data", 32'(bus.o_data), 32'h00);
        compare("rst_frame_last", 32'(bus.o_frame_last), 32'd0);
        compare("rst_busy", 32'(bus.o_busy), 32'd0);
        repeat (2) applyStimulus(1'b1, randomRow(), 1'b1, 1'b1);
        @(posedge dout_clk);
        #1;
        rst_n = 1'b1;
        bus.i_row_vld = 1'b0;
        #1;
        checkOutput();
        armed = 1'b1;
    endtask

    task automatic drainAll();
        for (int c = 0; c < 400 && expQ.size() > 0; c++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        compare("drain_done", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ROW_W-1:0] row;
        logic [ROW_W-1:0] rowB;
        int               cnt;
        int               flCnt;
        int               flIdx;
        logic             drdy;

        vecs[0] = '{8'h7F, 8'h7F};
        vecs[1] = '{8'h80, RELU_ON ? 8'h00 : 8'h80};
        vecs[2] = '{8'hFF, RELU_ON ? 8'h00 : 8'hFF};
        vecs[3] = '{8'h00, 8'h00};
        vecs[4] = '{8'h01, 8'h01};
        vecs[5] = '{8'h55, 8'h55};
        vecs[6] = '{8'hAA, RELU_ON ? 8'h00 : 8'hAA};
        vecs[7] = '{8'hC3, RELU_ON ? 8'h00 : 8'hC3};

        rst_n = 1'b0;
        en = 1'b0;
        bus.i_row_vld = 1'b0;
        bus.i_row_data = '0;
        bus.i_data_rdy = 1'b0;
        bytesSent = 0;
        rowsAccepted = 0;
        armed = 1'b0;

        resetDut();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        compare("post_reset_rdy", 32'(bus.o_row_rdy), 32'd1);

        // Single row 0x01..0x20, streamed back-to-back, busy clears after the last byte.
        for (int k = 0; k < ROW_BYTES; k++) row[ROW_W-1-8*k -: 8] = 8'(k + 1);
        applyStimulus(1'b1, row, 1'b1, 1'b1);
        for (int i = 0; i < ROW_BYTES; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            compare("seq_byte", 32'(bus.o_data), 32'(i + 1));
            compare("seq_vld", 32'(bus.o_data_vld), 32'd1);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        compare("busy_after_row", 32'(bus.o_busy), 32'd0);

        // Two rows back-to-back: second lands in PR, 64 bytes without a gap.
        row  = randomRow();
        rowB = randomRow();
        applyStimulus(1'b1, row, 1'b1, 1'b1);
        applyStimulus(1'b1, rowB, 1'b1, 1'b1);
        compare("b2b_first_vld", 32'(bus.o_data_vld), 32'd1);
        cnt = 0;
        for (int i = 0; i < 2 * ROW_BYTES - 1; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            if (i == 0) compare("pr_full_rdy", 32'(bus.o_row_rdy), 32'd0);
            if (bus.o_data_vld) cnt++;
        end
        compare("b2b_vld_cycles", 32'(cnt), 32'(2 * ROW_BYTES - 1));
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        compare("b2b_idle_after", 32'(bus.o_data_vld), 32'd0);

        // Vector table: byte values through the load path.
        for (int k = 0; k < ROW_BYTES; k++) row[ROW_W-1-8*k -: 8] = vecs[k % 8].inByte;
        applyStimulus(1'b1, row, 1'b1, 1'b1);
        for (int k = 0; k < ROW_BYTES; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            compare("vec_byte", 32'(bus.o_data), 32'(vecs[k % 8].outByte));
        end
        drainAll();

        // en low for 5 cycles at col 10 with a row offered: nothing moves.
        row = randomRow();
        applyStimulus(1'b1, row, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, randomRow(), 1'b1, 1'b0);
            compare("gap_vld", 32'(bus.o_data_vld), 32'd0);
            compare("gap_rdy", 32'(bus.o_row_rdy), 32'd0);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        compare("resume_byte", 32'(bus.o_data), 32'(reluRef(row[ROW_W-1-8*10 -: 8])));
        drainAll();

        // Reset at row 3, col 17 of a fresh frame.
        resetDut();
        for (int c = 0; c < 1000 && bytesSent < 3 * ROW_BYTES + 17; c++)
            applyStimulus(1'b1, randomRow(), 1'b1, 1'b1);
        compare("reach_r3c17", 32'(bytesSent), 32'(3 * ROW_BYTES + 17));
        resetDut();

        // Full frame with random downstream stalls.
        flCnt = 0;
        flIdx = -1;
        for (int c = 0; c < 20000 && bytesSent < FRAME; c++) begin
            drdy = ($urandom_range(0, 9) < 7);
            applyStimulus((rowsAccepted < ROWS) && ($urandom_range(0, 3) != 0), randomRow(), drdy, 1'b1);
            if (bus.o_frame_last && bus.o_data_vld && drdy) begin
                flCnt++;
                flIdx = bytesSent;
            end
        end
        compare("frame_bytes", 32'(bytesSent), 32'(FRAME));
        compare("frame_rows", 32'(rowsAccepted), 32'(ROWS));
        compare("frame_last_count", 32'(flCnt), 32'd1);
        compare("frame_last_pos", 32'(flIdx), 32'(FRAME));
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        compare("frame_end_busy", 32'(bus.o_busy), 32'd0);

        // Next frame starts again at row 0, col 0.
        row = randomRow();
        applyStimulus(1'b1, row, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        compare("next_frame_byte0", 32'(bus.o_data), 32'(reluRef(row[ROW_W-1 -: 8])));
        drainAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
